// File: rtl/sd_tx_fifo_sc_if.sv
// Host-side bus of the SD TX FIFO: write/read handshake, flush, status and error flags.
// The host drives through the master modport and the FIFO sits on the slave modport.
interface sd_tx_fifo_sc_if #(
  parameter int DATA_W = 32,
  parameter int ADR_W  = 4
);
  logic [DATA_W-1:0] d;
  logic [DATA_W-1:0] q;
  logic              wr;
  logic              rd;
  logic              clr;
  logic              err_clr;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADR_W:0]    fill_cnt;
  logic [ADR_W:0]    free_cnt;
  logic              ovf;
  logic              udf;

  modport master (
    output d, wr, rd, clr, err_clr,
    input  q, full, empty, almost_full, almost_empty, fill_cnt, free_cnt, ovf, udf
  );

  modport slave (
    input  d, wr, rd, clr, err_clr,
    output q, full, empty, almost_full, almost_empty, fill_cnt, free_cnt, ovf, udf
  );
endinterface

// File: rtl/sd_tx_fifo_sc.sv
// Single-clock TX FIFO feeding the SD data-line serializer: show-ahead or registered read,
// programmable almost-full/almost-empty thresholds, synchronous flush, sticky ovf/udf flags.
module sd_tx_fifo_sc #(
  parameter int DATA_W    = 32,
  parameter int ADR_W     = 4,
  parameter bit FWFT      = 1'b1,
  parameter int AF_THRESH = 12,
  parameter int AE_THRESH = 2
) (
  input logic                clk,
  input logic                rst_n,
  sd_tx_fifo_sc_if.slave     bus
);

  localparam int             DEPTH   = 2 ** ADR_W;
  localparam logic [ADR_W:0] DEPTH_V = (ADR_W + 1)'(DEPTH);
  localparam logic [ADR_W:0] AF_V    = (ADR_W + 1)'(AF_THRESH);
  localparam logic [ADR_W:0] AE_V    = (ADR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADR_W:0]    wptr;
  logic [ADR_W:0]    rptr;
  logic [ADR_W:0]    fill;
  logic              full_i;
  logic              empty_i;
  logic              wr_acc;
  logic              rd_acc;

  // The extra pointer MSB is the wrap bit that tells full apart from empty.
  assign empty_i = (wptr == rptr);
  assign full_i  = (wptr[ADR_W] != rptr[ADR_W]) &&
                   (wptr[ADR_W-1:0] == rptr[ADR_W-1:0]);
  assign fill    = wptr - rptr;

  assign wr_acc = rst_n & bus.wr & ~full_i  & ~bus.clr;
  assign rd_acc = rst_n & bus.rd & ~empty_i & ~bus.clr;

  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.fill_cnt     = fill;
  assign bus.free_cnt     = DEPTH_V - fill;
  assign bus.almost_full  = (fill >= AF_V);
  assign bus.almost_empty = (fill <= AE_V);

  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wptr[ADR_W-1:0]] <= bus.d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || bus.clr) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;
    end
  end

  // Flush leaves the error flags alone; a coincident err_clr loses to a new error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ovf <= 1'b0;
      bus.udf <= 1'b0;
    end else begin
      bus.ovf <= (bus.wr & full_i  & ~bus.clr) | (bus.ovf & ~bus.err_clr);
      bus.udf <= (bus.rd & empty_i & ~bus.clr) | (bus.udf & ~bus.err_clr);
    end
  end

  generate
    if (FWFT) begin : g_show_ahead
      assign bus.q = mem[rptr[ADR_W-1:0]];
    end else begin : g_registered
      logic [DATA_W-1:0] q_r;

      always_ff @(posedge clk) begin
        if (!rst_n || bus.clr)
          q_r <= '0;
        else if (rd_acc)
          q_r <= mem[rptr[ADR_W-1:0]];
      end

      assign bus.q = q_r;
    end
  endgenerate

endmodule

// File: tb/tb_sd_tx_fifo_sc.sv
// Directed bench for sd_tx_fifo_sc: one show-ahead instance and one registered-read instance,
// expectations hand-computed or taken from a small queue model of the stored words.
module tb_sd_tx_fifo_sc;

  logic clk = 1'b0;
  logic rst1_n;
  logic rst0_n;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] model_q[$];
  logic [31:0] next_val;

  always #5 clk = ~clk;

  sd_tx_fifo_sc_if #(.DATA_W(32), .ADR_W(4)) bus1 ();
  sd_tx_fifo_sc_if #(.DATA_W(32), .ADR_W(4)) bus0 ();

  sd_tx_fifo_sc #(.DATA_W(32), .ADR_W(4), .FWFT(1'b1), .AF_THRESH(12), .AE_THRESH(2)) dut1 (
    .clk   (clk),
    .rst_n (rst1_n),
    .bus   (bus1.slave)
  );

  sd_tx_fifo_sc #(.DATA_W(32), .ADR_W(4), .FWFT(1'b0), .AF_THRESH(12), .AE_THRESH(2)) dut0 (
    .clk   (clk),
    .rst_n (rst0_n),
    .bus   (bus0.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One registered-read transaction: rd seen at one edge, q must follow right after it.
  task automatic applyStimulus(input logic [31:0] prev_q, input logic [31:0] exp_q);
    bus0.rd = 1'b1;
    checkOutput("regq_before_edge", bus0.q, prev_q);
    tick();
    bus0.rd = 1'b0;
    checkOutput("regq_after_rd", bus0.q, exp_q);
    tick();
    tick();
    checkOutput("regq_hold", bus0.q, exp_q);
  endtask

  initial begin
    rst1_n = 1'b0; rst0_n = 1'b0;
    bus1.d = '0; bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.clr = 1'b0; bus1.err_clr = 1'b0;
    bus0.d = '0; bus0.wr = 1'b0; bus0.rd = 1'b0; bus0.clr = 1'b0; bus0.err_clr = 1'b0;
    tick();
    tick();
    rst1_n = 1'b1; rst0_n = 1'b1;
    tick();

    checkOutput("rst_empty", 32'(bus1.empty), 1);
    checkOutput("rst_full", 32'(bus1.full), 0);
    checkOutput("rst_fill", 32'(bus1.fill_cnt), 0);
    checkOutput("rst_free", 32'(bus1.free_cnt), 16);
    checkOutput("rst_aempty", 32'(bus1.almost_empty), 1);
    checkOutput("rst_afull", 32'(bus1.almost_full), 0);
    checkOutput("rst_ovf", 32'(bus1.ovf), 0);
    checkOutput("rst_udf", 32'(bus1.udf), 0);
    checkOutput("rst_regq", bus0.q, 32'h0);

    // Fill to DEPTH, tracking thresholds after every write.
    for (int i = 0; i < 16; i++) begin
      bus1.wr = 1'b1;
      bus1.d  = 32'h1000 + 32'(i);
      tick();
      checkOutput("fill_cnt", 32'(bus1.fill_cnt), 32'(i + 1));
      checkOutput("fill_afull", 32'(bus1.almost_full), 32'((i + 1) >= 12));
      checkOutput("fill_aempty", 32'(bus1.almost_empty), 32'((i + 1) <= 2));
      checkOutput("fill_full", 32'(bus1.full), 32'(i == 15));
    end
    checkOutput("full_free", 32'(bus1.free_cnt), 0);
    checkOutput("full_ovf_pre", 32'(bus1.ovf), 0);
    bus1.d = 32'hDEAD;
    tick();
    bus1.wr = 1'b0;
    checkOutput("ovf_set", 32'(bus1.ovf), 1);
    checkOutput("ovf_fill", 32'(bus1.fill_cnt), 16);
    checkOutput("ovf_head", bus1.q, 32'h1000);

    // Show-ahead drain: head word visible before each read, no wait cycle.
    for (int i = 0; i < 16; i++) begin
      bus1.rd = 1'b1;
      checkOutput("drain_q", bus1.q, 32'h1000 + 32'(i));
      tick();
    end
    checkOutput("drain_empty", 32'(bus1.empty), 1);
    checkOutput("drain_udf_pre", 32'(bus1.udf), 0);
    tick();
    bus1.rd = 1'b0;
    checkOutput("udf_set", 32'(bus1.udf), 1);
    checkOutput("udf_fill", 32'(bus1.fill_cnt), 0);
    bus1.err_clr = 1'b1;
    tick();
    bus1.err_clr = 1'b0;
    checkOutput("errclr_udf", 32'(bus1.udf), 0);
    checkOutput("errclr_ovf", 32'(bus1.ovf), 0);

    // Registered-read instance.
    bus0.wr = 1'b1; bus0.d = 32'hA5A5_0001;
    tick();
    bus0.d = 32'hA5A5_0002;
    tick();
    bus0.wr = 1'b0;
    checkOutput("regq_fill", 32'(bus0.fill_cnt), 2);
    applyStimulus(32'h0, 32'hA5A5_0001);
    applyStimulus(32'hA5A5_0001, 32'hA5A5_0002);
    checkOutput("regq_empty", 32'(bus0.empty), 1);

    // Prime to 5 words, then stream 40 with simultaneous wr/rd across pointer wraps.
    next_val = 32'h2000;
    for (int i = 0; i < 5; i++) begin
      bus1.wr = 1'b1; bus1.d = next_val;
      model_q.push_back(next_val);
      next_val++;
      tick();
    end
    checkOutput("prime_fill", 32'(bus1.fill_cnt), 5);
    for (int i = 0; i < 40; i++) begin
      bus1.wr = 1'b1; bus1.rd = 1'b1; bus1.d = next_val;
      checkOutput("stream_q", bus1.q, model_q[0]);
      tick();
      void'(model_q.pop_front());
      model_q.push_back(next_val);
      next_val++;
      checkOutput("stream_fill", 32'(bus1.fill_cnt), 5);
      checkOutput("stream_full", 32'(bus1.full), 0);
      checkOutput("stream_empty", 32'(bus1.empty), 0);
    end
    bus1.rd = 1'b0;

    // Grow to 9, then flush with wr/rd both high.
    for (int i = 0; i < 4; i++) begin
      bus1.d = next_val;
      model_q.push_back(next_val);
      next_val++;
      tick();
    end
    checkOutput("preclr_fill", 32'(bus1.fill_cnt), 9);
    bus1.wr = 1'b1; bus1.rd = 1'b1; bus1.clr = 1'b1; bus1.d = 32'hBAD0;
    tick();
    bus1.wr = 1'b0; bus1.rd = 1'b0; bus1.clr = 1'b0;
    model_q.delete();
    checkOutput("clr_empty", 32'(bus1.empty), 1);
    checkOutput("clr_fill", 32'(bus1.fill_cnt), 0);
    checkOutput("clr_free", 32'(bus1.free_cnt), 16);
    checkOutput("clr_ovf", 32'(bus1.ovf), 0);
    checkOutput("clr_udf", 32'(bus1.udf), 0);

    // A flagged udf survives a flush that carries a read.
    bus1.rd = 1'b1;
    tick();
    checkOutput("udf_again", 32'(bus1.udf), 1);
    bus1.clr = 1'b1; bus1.wr = 1'b1;
    tick();
    bus1.clr = 1'b0; bus1.wr = 1'b0; bus1.rd = 1'b0;
    checkOutput("clr_keeps_udf", 32'(bus1.udf), 1);
    checkOutput("clr2_fill", 32'(bus1.fill_cnt), 0);

    // Reset in the middle of a write burst.
    for (int i = 0; i < 3; i++) begin
      bus1.wr = 1'b1; bus1.d = 32'h3000 + 32'(i);
      tick();
    end
    checkOutput("burst_fill", 32'(bus1.fill_cnt), 3);
    rst1_n = 1'b0; bus1.d = 32'h3003;
    tick();
    rst1_n = 1'b1; bus1.wr = 1'b0;
    checkOutput("mrst_empty", 32'(bus1.empty), 1);
    checkOutput("mrst_fill", 32'(bus1.fill_cnt), 0);
    checkOutput("mrst_free", 32'(bus1.free_cnt), 16);
    checkOutput("mrst_aempty", 32'(bus1.almost_empty), 1);
    checkOutput("mrst_udf", 32'(bus1.udf), 0);
    bus1.wr = 1'b1; bus1.d = 32'h4444_5555;
    tick();
    bus1.wr = 1'b0;
    checkOutput("post_rst_q", bus1.q, 32'h4444_5555);
    checkOutput("post_rst_fill", 32'(bus1.fill_cnt), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
